// File: rtl/ghash_sequencer.sv
// Sequences one GHASH pass (AAD blocks, CT blocks, length block) over an external
// GF(2^128) multiply-add unit and produces the GCM tag Y ^ E(K,J0).
module ghash_sequencer #(
    parameter int MUL_LATENCY = 2,
    parameter int LEN_W       = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [0:127]     h_key,
    input  logic [0:127]     ek_j0,
    input  logic [0:LEN_W-1] aad_len,
    input  logic [0:LEN_W-1] ct_len,
    input  logic             blk_valid,
    input  logic [0:127]     blk_data,
    output logic             blk_ready,
    output logic             mul_issue,
    output logic [0:127]     mul_x,
    output logic [0:127]     mul_y,
    output logic [0:127]     mul_h,
    input  logic [0:127]     mul_o,
    output logic             busy,
    output logic [0:127]     tag,
    output logic             tag_valid
);

    localparam int CNT_W = LEN_W - 6;

    typedef enum logic [2:0] {
        S_IDLE, S_AAD, S_CT, S_LEN, S_ISSUE, S_WAIT, S_FINAL
    } state_t;

    state_t           state;
    state_t           origin;
    logic [0:127]     y_reg;
    logic [0:127]     h_reg;
    logic [0:127]     ek_reg;
    logic [LEN_W-1:0] aad_len_r;
    logic [LEN_W-1:0] ct_len_r;
    logic [CNT_W-1:0] aad_cnt;
    logic [CNT_W-1:0] ct_cnt;
    logic [3:0]       wait_cnt;

    logic [LEN_W-1:0] aad_in;
    logic [LEN_W-1:0] ct_in;
    logic [CNT_W-1:0] n_aad;
    logic [CNT_W-1:0] n_ct;
    logic [0:127]     len_block;
    logic [6:0]       sec_r;
    logic             sec_last;
    logic [0:127]     blk_masked;

    function automatic logic [CNT_W-1:0] blocks_of(input logic [LEN_W-1:0] len);
        return CNT_W'(len >> 7) + CNT_W'(|len[6:0]);
    endfunction

    // Bit 0 is the first transmitted bit, so the r valid bits sit at the top of the value.
    function automatic logic [0:127] last_mask(input logic [6:0] r);
        logic [0:127] ones;
        ones = '1;
        return (r == 7'd0) ? ones : ~(ones >> r);
    endfunction

    assign aad_in    = aad_len;
    assign ct_in     = ct_len;
    assign n_aad     = blocks_of(aad_in);
    assign n_ct      = blocks_of(ct_in);
    assign len_block = {64'(aad_len_r), 64'(ct_len_r)};

    always_comb begin
        sec_r      = (state == S_AAD) ? aad_len_r[6:0] : ct_len_r[6:0];
        sec_last   = (state == S_AAD) ? (aad_cnt == CNT_W'(1)) : (ct_cnt == CNT_W'(1));
        blk_masked = sec_last ? (blk_data & last_mask(sec_r)) : blk_data;
    end

    // Single controller; operands are loaded on the edge entering ISSUE and then held.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            origin    <= S_IDLE;
            y_reg     <= '0;
            h_reg     <= '0;
            ek_reg    <= '0;
            aad_len_r <= '0;
            ct_len_r  <= '0;
            aad_cnt   <= '0;
            ct_cnt    <= '0;
            wait_cnt  <= '0;
            blk_ready <= 1'b0;
            mul_issue <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            mul_h     <= '0;
            busy      <= 1'b0;
            tag       <= '0;
            tag_valid <= 1'b0;
        end else begin
            mul_issue <= 1'b0;
            tag_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        h_reg     <= h_key;
                        ek_reg    <= ek_j0;
                        aad_len_r <= aad_in;
                        ct_len_r  <= ct_in;
                        aad_cnt   <= n_aad;
                        ct_cnt    <= n_ct;
                        y_reg     <= '0;
                        busy      <= 1'b1;
                        if (n_aad != '0) begin
                            state     <= S_AAD;
                            blk_ready <= 1'b1;
                        end else if (n_ct != '0) begin
                            state     <= S_CT;
                            blk_ready <= 1'b1;
                        end else begin
                            state <= S_LEN;
                        end
                    end
                end
                S_AAD, S_CT: begin
                    if (blk_valid && blk_ready) begin
                        blk_ready <= 1'b0;
                        mul_x     <= blk_masked;
                        mul_y     <= y_reg;
                        mul_h     <= h_reg;
                        mul_issue <= 1'b1;
                        origin    <= state;
                        state     <= S_ISSUE;
                        if (state == S_AAD) aad_cnt <= aad_cnt - CNT_W'(1);
                        else                ct_cnt  <= ct_cnt - CNT_W'(1);
                    end
                end
                S_LEN: begin
                    mul_x     <= len_block;
                    mul_y     <= y_reg;
                    mul_h     <= h_reg;
                    mul_issue <= 1'b1;
                    origin    <= S_LEN;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'(MUL_LATENCY - 1)) begin
                        y_reg <= mul_o;
                        case (origin)
                            S_AAD: begin
                                if (aad_cnt != '0) begin
                                    state     <= S_AAD;
                                    blk_ready <= 1'b1;
                                end else if (ct_cnt != '0) begin
                                    state     <= S_CT;
                                    blk_ready <= 1'b1;
                                end else begin
                                    state <= S_LEN;
                                end
                            end
                            S_CT: begin
                                if (ct_cnt != '0) begin
                                    state     <= S_CT;
                                    blk_ready <= 1'b1;
                                end else begin
                                    state <= S_LEN;
                                end
                            end
                            default: state <= S_FINAL;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_FINAL: begin
                    tag       <= y_reg ^ ek_reg;
                    tag_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
